totp_timebase: RTL and testbench
================================

TOTP_TIMEBASE -- requirements
Module: totp_timebase

Interface
REQ-001 The block SHALL have parameter CLK_HZ, default 100000000, clk cycles per second.
REQ-002 The block SHALL have parameter TIME_W, default 64, width of time and step counters.
REQ-003 The block SHALL have parameter STEP_W, default 8, width of the step-period field in seconds.
REQ-004 The block SHALL have parameter STEP_DEF, default 30, step period used when the step_sec input is 0.
REQ-005 The block SHALL have port clk, input, 1, clock.
REQ-006 The block SHALL have port rst, input, 1: reset, synchronous, active-high; clock clk.
REQ-007 The block SHALL have port sync_valid, input, 1, one-cycle request to load sync_time.
REQ-008 The block SHALL have port sync_time, input, TIME_W, Unix seconds to load.
REQ-009 The block SHALL have port step_sec, input, STEP_W, step period in seconds, sampled at sync start and at reset.
REQ-010 The block SHALL have port unix_time, output, TIME_W, current Unix seconds.
REQ-011 The block SHALL have port step_count, output, TIME_W, TOTP counter T = floor(unix_time/period).
REQ-012 The block SHALL have port step_remain, output, STEP_W, seconds left in the current step, range period..1.
REQ-013 The block SHALL have port sec_tick, output, 1, one-cycle pulse per second.
REQ-014 The block SHALL have port step_tick, output, 1, one-cycle pulse whenever step_count changes or is reloaded.
REQ-015 The block SHALL have port busy, output, 1, high while a sync division is in progress.

Function
REQ-016 The effective period SHALL be step_sec, or STEP_DEF when step_sec==0, latched into an internal register; it SHALL NOT change between latch points.
REQ-017 In state RUN, the prescaler SHALL count 0..CLK_HZ-1; on the terminal count it SHALL wrap to 0, pulse sec_tick, and increment unix_time modulo 2^TIME_W.
REQ-018 On each sec_tick, step_remain SHALL decrement; when it is 1, it SHALL reload to period, step_count SHALL increment modulo 2^TIME_W, and step_tick SHALL pulse in the same cycle as sec_tick.
REQ-019 A sync_valid in RUN SHALL latch sync_time and the period, then enter state DIV; that sync wins over a coincident terminal count, and the tick SHALL be dropped.
REQ-020 DIV SHALL run a restoring divider, one quotient bit per cycle for TIME_W cycles, with busy=1, the prescaler held at 0, and sec_tick/step_tick suppressed.
REQ-021 After DIV, state LOAD (one cycle) SHALL apply the results and return to RUN:
- unix_time=sync_time
- step_count=quotient
- step_remain=period-remainder
- step_tick pulses
- busy=0
REQ-022 Sync latency SHALL be TIME_W+2 cycles from sync_valid to updated outputs; the prescaler restarts from 0 in the first RUN cycle.
REQ-023 sync_valid while busy=1 SHALL be ignored.
REQ-024 unix_time all-ones SHALL wrap to 0 on the next second; step_count and step_remain SHALL continue normally, with no step re-alignment.

Reset
REQ-025 While rst=1, the block SHALL hold:
- state=RUN, prescaler=0
- unix_time=0, step_count=0
- step_remain=period (latched from step_sec)
- sec_tick=0, busy=0
- step_tick=1, so downstream HOTP recomputes after reset
REQ-026 rst SHALL have priority over all inputs; a reset during DIV SHALL abort the division and discard the latched sync_time.

Configuration
REQ-027 With macro TOTP_DRIFT_TRIM_EN defined, the block SHALL add input port trim, signed 16 bits, and use prescaler terminal count CLK_HZ-1+trim, sampled at each wrap.
REQ-028 Without TOTP_DRIFT_TRIM_EN, the trim port SHALL be absent and the terminal count SHALL be fixed at CLK_HZ-1.

Verification
REQ-029 Bench with CLK_HZ=10, STEP_DEF=30, step_sec=0; release reset and run 300 cycles -> sec_tick every 10 cycles, unix_time=30, step_count=1, step_tick pulses on the 30th second.
REQ-030 sync_time=59, step_sec=30 -> busy for 64 cycles, then unix_time=59, step_count=1, step_remain=1, step_tick pulse; 10 cycles later step_count=2, step_remain=30.
REQ-031 sync_valid coincident with the prescaler terminal count -> no sec_tick, and unix_time equals sync_time after LOAD.
REQ-032 Second sync_valid at DIV cycle 5 -> ignored, and the first sync result is loaded.
REQ-033 rst asserted at DIV cycle 20 -> busy=0, unix_time=0 after reset.
REQ-034 sync_time=2^64-1, step_sec=1 -> unix_time=0 one second later, step_count increments.

Source files
------------

// File: rtl/totp_timebase.sv
// totp_timebase: free-running Unix-seconds counter with a TOTP step counter.
// A sync request loads a new Unix time and derives step_count/step_remain
// from it with a bit-serial restoring divider (one quotient bit per cycle).
// Optional feature: define TOTP_DRIFT_TRIM_EN to add a signed 16-bit `trim`
// input that adjusts the prescaler terminal count, re-sampled at every wrap.

module totp_timebase #(
    parameter int CLK_HZ   = 100000000,
    parameter int TIME_W   = 64,
    parameter int STEP_W   = 8,
    parameter int STEP_DEF = 30
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               sync_valid,
    input  logic [TIME_W-1:0]  sync_time,
    input  logic [STEP_W-1:0]  step_sec,
`ifdef TOTP_DRIFT_TRIM_EN
    input  logic signed [15:0] trim,
`endif
    output logic [TIME_W-1:0]  unix_time,
    output logic [TIME_W-1:0]  step_count,
    output logic [STEP_W-1:0]  step_remain,
    output logic               sec_tick,
    output logic               step_tick,
    output logic               busy
);

`ifdef TOTP_DRIFT_TRIM_EN
    localparam int PRE_W = $clog2(CLK_HZ + 32768);
`else
    localparam int PRE_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
`endif
    localparam int CNT_W = $clog2(TIME_W + 1);

    typedef enum logic [1:0] {
        RUN,
        DIV,
        LOAD
    } state_t;

    state_t state, state_next;

    // Period and prescaler
    logic [STEP_W-1:0] eff_period;
    logic [STEP_W-1:0] period_q;
    logic [PRE_W-1:0]  presc_q;
    logic [PRE_W-1:0]  term;
    logic              at_term;

    // FSM strobes
    logic accept_sync;
    logic run_tick;
    logic div_step;
    logic div_last;
    logic load_en;

    // Divider
    logic [TIME_W-1:0] sync_q;
    logic [TIME_W-1:0] div_quot;
    logic [STEP_W-1:0] div_rem;
    logic [STEP_W-1:0] rem_next;
    logic [STEP_W:0]   partial;
    logic              fits;
    logic [CNT_W-1:0]  div_cnt;

    // A zero step_sec selects the default period.
    assign eff_period = (step_sec == '0) ? STEP_W'(STEP_DEF) : step_sec;
    assign at_term    = (presc_q == term);

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) state <= RUN;
        else     state <= state_next;
    end

    // Next-state logic: RUN -> DIV on sync, DIV -> LOAD after the last bit, LOAD -> RUN.
    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (sync_valid) state_next = DIV;
            DIV:     if (div_last)   state_next = LOAD;
            LOAD:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Output/strobe decode; a sync in RUN wins over a coincident terminal count.
    always_comb begin
        busy        = (state == DIV);
        accept_sync = (state == RUN) && sync_valid;
        run_tick    = (state == RUN) && !sync_valid && at_term;
        div_step    = (state == DIV);
        div_last    = (state == DIV) && (div_cnt == CNT_W'(TIME_W - 1));
        load_en     = (state == LOAD);
    end

`ifdef TOTP_DRIFT_TRIM_EN
    logic [PRE_W-1:0] trim_term;
    int               term_calc;

    // Trimmed terminal count, clamped at zero for extreme negative trims.
    always_comb begin
        term_calc = CLK_HZ - 1 + int'(trim);
        trim_term = (term_calc < 0) ? '0 : PRE_W'(term_calc);
    end

    // Re-sample the terminal count whenever the prescaler restarts from 0.
    always_ff @(posedge clk) begin
        if (rst || (state != RUN) || accept_sync || run_tick) term <= trim_term;
    end
`else
    assign term = PRE_W'(CLK_HZ - 1);
`endif

    // One restoring-division step: shift in the next dividend bit, subtract if it fits.
    assign partial = {div_rem, div_quot[TIME_W-1]};
    assign fits    = (partial >= {1'b0, period_q});

    // Remainder after the current step; always below the period, so it fits STEP_W bits.
    always_comb begin
        rem_next = STEP_W'(partial);
        if (fits) rem_next = STEP_W'(partial - {1'b0, period_q});
    end

    // Divider operands: loaded on an accepted sync, then one quotient bit per DIV cycle.
    // NOTE: these registers carry no reset; they are always loaded before use and a reset
    // returns the FSM to RUN, so a half-finished division can never reach LOAD.
    always_ff @(posedge clk) begin
        if (accept_sync) begin
            sync_q   <= sync_time;
            div_quot <= sync_time;
            div_rem  <= '0;
            div_cnt  <= '0;
        end else if (div_step) begin
            div_quot <= {div_quot[TIME_W-2:0], fits};
            div_rem  <= rem_next;
            div_cnt  <= div_cnt + CNT_W'(1);
        end
    end

    // Timekeeping: prescaler, seconds, step counter, tick pulses and sync load.
    always_ff @(posedge clk) begin
        if (rst) begin
            period_q    <= eff_period;
            presc_q     <= '0;
            unix_time   <= '0;
            step_count  <= '0;
            step_remain <= eff_period;
            sec_tick    <= 1'b0;
            step_tick   <= 1'b1;
        end else begin
            sec_tick  <= 1'b0;
            step_tick <= 1'b0;
            if (accept_sync) begin
                period_q <= eff_period;
                presc_q  <= '0;
            end else if (run_tick) begin
                presc_q   <= '0;
                sec_tick  <= 1'b1;
                unix_time <= unix_time + TIME_W'(1);
                if (step_remain == STEP_W'(1)) begin
                    step_remain <= period_q;
                    step_count  <= step_count + TIME_W'(1);
                    step_tick   <= 1'b1;
                end else begin
                    step_remain <= step_remain - STEP_W'(1);
                end
            end else if (state == RUN) begin
                presc_q <= presc_q + PRE_W'(1);
            end else begin
                presc_q <= '0;
            end

            if (load_en) begin
                unix_time   <= sync_q;
                step_count  <= div_quot;
                step_remain <= period_q - div_rem;
                step_tick   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_totp_timebase.sv
// Self-checking bench for totp_timebase: stimulus pushes expected tick/load
// events into a queue; a monitor pops and compares on every sec_tick/step_tick.

module tb_totp_timebase;

    localparam int CLK_HZ   = 10;
    localparam int TIME_W   = 64;
    localparam int STEP_W   = 8;
    localparam int STEP_DEF = 30;
    localparam int SYNC_LAT = TIME_W + 2;   // edges from sync accept-cycle to updated outputs

    logic              clk;
    logic              rst;
    logic              sync_valid;
    logic [TIME_W-1:0] sync_time;
    logic [STEP_W-1:0] step_sec;
    logic [TIME_W-1:0] unix_time;
    logic [TIME_W-1:0] step_count;
    logic [STEP_W-1:0] step_remain;
    logic              sec_tick;
    logic              step_tick;
    logic              busy;

    totp_timebase #(
        .CLK_HZ   (CLK_HZ),
        .TIME_W   (TIME_W),
        .STEP_W   (STEP_W),
        .STEP_DEF (STEP_DEF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sync_valid  (sync_valid),
        .sync_time   (sync_time),
        .step_sec    (step_sec),
`ifdef TOTP_DRIFT_TRIM_EN
        .trim        (16'sd0),
`endif
        .unix_time   (unix_time),
        .step_count  (step_count),
        .step_remain (step_remain),
        .sec_tick    (sec_tick),
        .step_tick   (step_tick),
        .busy        (busy)
    );

    typedef struct {
        longint unsigned cyc;
        logic [63:0]     unix;
        logic [63:0]     count;
        logic [7:0]      remain;
        logic            sec;
        logic            stp;
    } ev_t;

    ev_t             exp_q[$];
    ev_t             mon_e;
    longint unsigned cyc = 0;
    int              n_checks = 0;
    int              n_err = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Reference model: after a load of time t with period p at cycle base, second k
    // arrives at base + k*CLK_HZ; the phase inside the step is (t mod p) + k.
    task automatic start_segment(input longint unsigned base, input logic [63:0] t,
                                 input int p, input longint unsigned run_len);
        ev_t             e;
        logic [63:0]     pp;
        logic [63:0]     s;
        longint unsigned k;
        pp       = 64'(p);
        e.cyc    = base;
        e.unix   = t;
        e.count  = t / pp;
        e.remain = 8'(pp - (t % pp));
        e.sec    = 1'b0;
        e.stp    = 1'b1;
        exp_q.push_back(e);
        k = 1;
        while (k * 64'(CLK_HZ) <= run_len) begin
            s        = (t % pp) + k;
            e.cyc    = base + k * 64'(CLK_HZ);
            e.unix   = t + k;
            e.count  = (t / pp) + (s / pp);
            e.remain = 8'(pp - (s % pp));
            e.sec    = 1'b1;
            e.stp    = ((s % pp) == 0);
            exp_q.push_back(e);
            k++;
        end
    endtask

    // Hold reset for `hold` edges (each shows reset values with step_tick=1), then run.
    task automatic do_reset(input logic [7:0] sv, input int hold, input longint unsigned run_len);
        int              p;
        ev_t             e;
        longint unsigned c0;
        p  = (sv == 0) ? STEP_DEF : int'(sv);
        c0 = cyc;
        for (int i = 1; i < hold; i++) begin
            e.cyc = c0 + 64'(i); e.unix = '0; e.count = '0;
            e.remain = 8'(p); e.sec = 1'b0; e.stp = 1'b1;
            exp_q.push_back(e);
        end
        rst        = 1'b1;
        step_sec   = sv;
        sync_valid = 1'b0;
        tick1();
        check("rst_unix_time", unix_time, 0);
        check("rst_step_count", step_count, 0);
        check("rst_step_remain", 64'(step_remain), 64'(p));
        check("rst_sec_tick", 64'(sec_tick), 0);
        check("rst_step_tick", 64'(step_tick), 1);
        check("rst_busy", 64'(busy), 0);
        repeat (hold - 1) tick1();
        rst = 1'b0;
        start_segment(cyc, '0, p, run_len);
        c0       = cyc;
        step_sec = 8'($urandom);
        while (cyc < c0 + run_len) tick1();
    endtask

    // Issue a sync; optionally a second (ignored) sync at DIV cycle second_at,
    // or stop at DIV cycle abort_at so the caller can reset mid-division.
    task automatic do_sync(input logic [63:0] t, input logic [7:0] sv, input longint unsigned run_len,
                           input int abort_at, input int second_at);
        longint unsigned a;
        longint unsigned base;
        int              p;
        int              busy_n;
        a    = cyc;
        p    = (sv == 0) ? STEP_DEF : int'(sv);
        base = a + 64'(SYNC_LAT);
        if (abort_at == 0) start_segment(base, t, p, run_len);
        sync_time  = t;
        step_sec   = sv;
        sync_valid = 1'b1;
        busy_n     = 0;
        for (int i = 1; i <= SYNC_LAT; i++) begin
            tick1();
            sync_valid = 1'b0;
            if (i == 1) step_sec = 8'($urandom);
            if (busy) busy_n++;
            if (i == second_at) begin
                sync_valid = 1'b1;
                sync_time  = ~t;
            end
            if (i == abort_at) break;
        end
        if (abort_at != 0) begin
            check("busy_in_div", 64'(busy), 1);
        end else begin
            check("busy_cycles", 64'(busy_n), 64'(TIME_W));
            check("busy_after_load", 64'(busy), 0);
            while (cyc < base + run_len) tick1();
        end
    endtask

    // Monitor: every tick or load pulse must match the next expected event.
    always @(negedge clk) begin
        if (sec_tick || step_tick) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_event: actual cyc=%0d unix=%0h required no event", cyc, unix_time);
            end else begin
                mon_e = exp_q.pop_front();
                check("ev_cycle", cyc, mon_e.cyc);
                check("ev_unix_time", unix_time, mon_e.unix);
                check("ev_step_count", step_count, mon_e.count);
                check("ev_step_remain", 64'(step_remain), 64'(mon_e.remain));
                check("ev_sec_tick", 64'(sec_tick), 64'(mon_e.sec));
                check("ev_step_tick", 64'(step_tick), 64'(mon_e.stp));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        sync_valid = 1'b0;
        sync_time  = '0;
        step_sec   = '0;

        // Default period, 300+ cycles of free running.
        do_reset(8'd0, 3, 305);
        // Sync 59 with period 30, then a sync coincident with the terminal count.
        do_sync(64'd59, 8'd30, 29, 0, 0);
        do_sync({$urandom, $urandom}, 8'($urandom_range(1, 255)), 40, 0, 0);
        // Second sync during DIV is ignored.
        do_sync({$urandom, $urandom}, 8'($urandom_range(0, 255)), 45, 0, 5);
        // Reset at DIV cycle 20 aborts the division.
        do_sync({$urandom, $urandom}, 8'($urandom_range(0, 255)), 0, 20, 0);
        do_reset(8'($urandom_range(0, 255)), 2, 50);
        // unix_time wrap from all-ones with a 1-second period.
        do_sync({64{1'b1}}, 8'd1, 25, 0, 0);
        // Randomised syncs and periods.
        for (int n = 0; n < 8; n++) begin
            do_sync({$urandom, $urandom}, 8'($urandom_range(0, 255)),
                    longint'($urandom_range(5, 60)), 0, 0);
        end
        // Final reset drains the expected queue.
        do_reset(8'd0, 2, 0);
        tick1();
        check("queue_drained", 64'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
